// File: rtl/acc_result_fifo_if.sv
// Result-FIFO bus: accumulator capture side, consumer handshake side and status.
// slave = FIFO side, master = accumulator/consumer/monitor side.
interface acc_result_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] acc_out;
    logic              count_9;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic [AW:0]       level;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              clr_ovf;
    logic [15:0]       result_count;

    modport slave (
        input  acc_out, count_9, dout_ready, clr_ovf,
        output dout, dout_valid, level, full, empty, overflow, result_count
    );

    modport master (
        output acc_out, count_9, dout_ready, clr_ovf,
        input  dout, dout_valid, level, full, empty, overflow, result_count
    );
endinterface

// File: rtl/acc_result_fifo.sv
// First-word-fall-through FIFO capturing 9-sample sums on count_9 strobes,
// with valid/ready drain, sticky overflow and an accepted-result counter.
module acc_result_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    acc_result_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              r_overflow;
    logic [15:0]       r_result_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Status comes from the level counter so pointer equality never has to
    // disambiguate full from empty.
    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);
    assign w_pop   = !w_empty && bus.dout_ready;
    assign w_push  = bus.count_9 && (!w_full || w_pop);
    assign w_drop  = bus.count_9 && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_overflow     <= 1'b0;
            r_result_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr       <= r_wr_ptr + AW'(1);
                r_result_count <= r_result_count + 16'd1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop)
                r_overflow <= 1'b1;
            else if (bus.clr_ovf)
                r_overflow <= 1'b0;
        end
    end

    // Storage is never cleared; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && w_push)
            r_mem[r_wr_ptr] <= bus.acc_out;
    end

    assign bus.dout         = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.dout_valid   = !w_empty;
    assign bus.level        = r_level;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.overflow     = r_overflow;
    assign bus.result_count = r_result_count;
endmodule

// File: tb/tb_acc_result_fifo.sv
// Bench for acc_result_fifo: directed vector table, hand sequences and random
// traffic, all checked against a queue-based reference model.
module tb_acc_result_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst;

    acc_result_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    acc_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: an ordered queue of stored sums plus flags.
    int m_q[$];
    bit m_ovf;
    int m_cnt;

    typedef struct {
        bit       c9;
        bit [7:0] d;
        bit       rdy;
        bit       clr;
        int       e_dout;
        int       e_lvl;
        bit       e_ovf;
        int       e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit pop, full, set;
        if (rst) begin
            m_q.delete();
            m_ovf = 0;
            m_cnt = 0;
        end else begin
            pop  = (m_q.size() != 0) && bus.dout_ready;
            full = (m_q.size() == DEPTH);
            set  = 0;
            if (pop) void'(m_q.pop_front());
            if (bus.count_9) begin
                if (!full || pop) begin
                    m_q.push_back(int'(bus.acc_out));
                    m_cnt = (m_cnt + 1) % 65536;
                end else begin
                    set = 1;
                end
            end
            if (set) m_ovf = 1;
            else if (bus.clr_ovf) m_ovf = 0;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_dout"},  int'(bus.dout),         (m_q.size() != 0) ? m_q[0] : 0);
        chk({tag, "_valid"}, int'(bus.dout_valid),   int'(m_q.size() != 0));
        chk({tag, "_level"}, int'(bus.level),        m_q.size());
        chk({tag, "_full"},  int'(bus.full),         int'(m_q.size() == DEPTH));
        chk({tag, "_empty"}, int'(bus.empty),        int'(m_q.size() == 0));
        chk({tag, "_ovf"},   int'(bus.overflow),     int'(m_ovf));
        chk({tag, "_cnt"},   int'(bus.result_count), m_cnt);
    endtask

    // Inputs are already driven; advance one edge and compare away from it.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk_model(tag);
    endtask

    task automatic drive(input bit c9, input int d, input bit rdy, input bit clr);
        bus.count_9    = c9;
        bus.acc_out    = DATA_W'(d);
        bus.dout_ready = rdy;
        bus.clr_ovf    = clr;
    endtask

    task automatic add(input bit c9, input int d, input bit rdy, input bit clr,
                       input int e_dout, input int e_lvl, input bit e_ovf, input int e_cnt);
        vec_t v;
        v.c9 = c9; v.d = 8'(d); v.rdy = rdy; v.clr = clr;
        v.e_dout = e_dout; v.e_lvl = e_lvl; v.e_ovf = e_ovf; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0);

        // Directed table, starting from an empty FIFO with result_count 0.
        add(1, 45, 0, 0, 45, 1, 0, 1);
        add(0, 0,  1, 0, 0,  0, 0, 1);
        add(1, 10, 0, 0, 10, 1, 0, 2);
        add(1, 20, 0, 0, 10, 2, 0, 3);
        add(1, 30, 0, 0, 10, 3, 0, 4);
        add(1, 40, 0, 0, 10, 4, 0, 5);
        add(0, 0,  1, 0, 20, 3, 0, 5);
        add(0, 0,  1, 0, 30, 2, 0, 5);
        add(0, 0,  1, 0, 40, 1, 0, 5);
        add(0, 0,  1, 0, 0,  0, 0, 5);
        add(1, 1,  0, 0, 1,  1, 0, 6);
        add(1, 2,  0, 0, 1,  2, 0, 7);
        add(1, 3,  0, 0, 1,  3, 0, 8);
        add(1, 4,  0, 0, 1,  4, 0, 9);
        add(1, 5,  0, 0, 1,  4, 1, 9);
        add(0, 0,  1, 0, 2,  3, 1, 9);
        add(0, 0,  1, 0, 3,  2, 1, 9);
        add(0, 0,  1, 0, 4,  1, 1, 9);
        add(0, 0,  1, 0, 0,  0, 1, 9);
        add(0, 0,  0, 1, 0,  0, 0, 9);
        add(1, 1,  0, 0, 1,  1, 0, 10);
        add(1, 2,  0, 0, 1,  2, 0, 11);
        add(1, 3,  0, 0, 1,  3, 0, 12);
        add(1, 4,  0, 0, 1,  4, 0, 13);
        add(1, 9,  1, 0, 2,  4, 0, 14);
        add(0, 0,  1, 0, 3,  3, 0, 14);
        add(0, 0,  1, 0, 4,  2, 0, 14);
        add(0, 0,  1, 0, 9,  1, 0, 14);
        add(0, 0,  1, 0, 0,  0, 0, 14);
        add(1, 1,  0, 0, 1,  1, 0, 15);
        add(1, 2,  0, 0, 1,  2, 0, 16);
        add(1, 3,  0, 0, 1,  3, 0, 17);
        add(1, 4,  0, 0, 1,  4, 0, 18);
        add(1, 7,  0, 1, 1,  4, 1, 18);
        add(0, 0,  0, 1, 1,  4, 0, 18);
        add(0, 0,  1, 0, 2,  3, 0, 18);
        add(0, 0,  1, 0, 3,  2, 0, 18);
        add(0, 0,  1, 0, 4,  1, 0, 18);
        add(0, 0,  1, 0, 0,  0, 0, 18);

        // Reset state.
        step("rst0");
        step("rst1");
        chk("rst_level", int'(bus.level), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_dout",  int'(bus.dout), 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].c9, int'(tbl[i].d), tbl[i].rdy, tbl[i].clr);
            step("tbl");
            chk($sformatf("tbl%0d_dout", i), int'(bus.dout), tbl[i].e_dout);
            chk($sformatf("tbl%0d_lvl", i),  int'(bus.level), tbl[i].e_lvl);
            chk($sformatf("tbl%0d_ovf", i),  int'(bus.overflow), int'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d_cnt", i),  int'(bus.result_count), tbl[i].e_cnt);
        end

        // Streaming with ready held high: each value visible one edge after its push.
        for (int v = 1; v <= 12; v++) begin
            drive(1, v, 1, 0);
            step("strm");
            chk("strm_dout", int'(bus.dout), v);
            chk("strm_lvl",  int'(bus.level), 1);
        end
        drive(0, 0, 1, 0);
        step("strm_end");
        chk("strm_cnt", int'(bus.result_count), 30);
        chk("strm_ovf", int'(bus.overflow), 0);

        // Reset with level 3, overflow set and a push pending.
        for (int v = 1; v <= 5; v++) begin
            drive(1, v * 11, 0, 0);
            step("pre_rst");
        end
        drive(0, 0, 1, 0);
        step("pre_rst_pop");
        chk("pre_rst_lvl", int'(bus.level), 3);
        chk("pre_rst_ovf", int'(bus.overflow), 1);
        rst = 1'b1;
        drive(1, 99, 1, 1);
        step("mid_rst");
        chk("mid_rst_cnt",   int'(bus.result_count), 0);
        chk("mid_rst_valid", int'(bus.dout_valid), 0);
        chk("mid_rst_ovf",   int'(bus.overflow), 0);
        rst = 1'b0;
        drive(1, 77, 0, 0);
        step("post_rst");
        chk("post_rst_dout", int'(bus.dout), 77);
        chk("post_rst_cnt",  int'(bus.result_count), 1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 1), int'($urandom_range(0, 255)),
                  $urandom_range(0, 2) != 0 ? 1'b0 : 1'b1, $urandom_range(0, 9) == 0);
            step("rnd");
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
